// File: rtl/alu_hw_driver.sv
// ALU stimulus driver: accepts transactions from a valid/ready stream and
// drives them onto the ALU input handshake after a per-transaction idle delay.
module alu_hw_driver #(
    parameter int DATA_WIDTH  = 8,
    parameter int DELAY_WIDTH = 8,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   TX_VLD,
    output logic                   TX_RDY,
    input  logic [1:0]             TX_OP,
    input  logic [1:0]             TX_MOVI,
    input  logic [DATA_WIDTH-1:0]  TX_REG_A,
    input  logic [DATA_WIDTH-1:0]  TX_REG_B,
    input  logic [DATA_WIDTH-1:0]  TX_MEM,
    input  logic [DATA_WIDTH-1:0]  TX_IMM,
    input  logic [DELAY_WIDTH-1:0] TX_DELAY,
    output logic                   ACT,
    output logic [1:0]             OP,
    output logic [1:0]             MOVI,
    output logic [DATA_WIDTH-1:0]  REG_A,
    output logic [DATA_WIDTH-1:0]  REG_B,
    output logic [DATA_WIDTH-1:0]  MEM,
    output logic [DATA_WIDTH-1:0]  IMM,
    input  logic                   ALU_RDY,
    output logic                   BUSY,
    output logic [CNT_WIDTH-1:0]   TRANS_CNT
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_DELAY = 2'd1,
        DRIVE      = 2'd2
    } state_t;

    state_t                 state, state_nx;
    logic [DELAY_WIDTH-1:0] dly, dly_nx;
    logic [CNT_WIDTH-1:0]   cnt_nx;
    logic [1:0]             op_nx, movi_nx;
    logic [DATA_WIDTH-1:0]  reg_a_nx, reg_b_nx, mem_nx, imm_nx;
    logic                   accept, xfer;

    assign ACT  = (state == DRIVE);
    assign BUSY = (state != IDLE);

    always_comb begin
        state_nx = state;
        dly_nx   = dly;
        cnt_nx   = TRANS_CNT;
        op_nx    = OP;
        movi_nx  = MOVI;
        reg_a_nx = REG_A;
        reg_b_nx = REG_B;
        mem_nx   = MEM;
        imm_nx   = IMM;
        TX_RDY   = 1'b0;
        xfer     = ACT && ALU_RDY;

        // In DRIVE a new transaction may ride on the transfer cycle
        unique case (state)
            IDLE:    TX_RDY = RST;
            DRIVE:   TX_RDY = RST && ALU_RDY;
            default: TX_RDY = 1'b0;
        endcase
        accept = TX_VLD && TX_RDY;

        if (xfer) begin
            cnt_nx   = TRANS_CNT + CNT_WIDTH'(1);
            state_nx = IDLE;
        end

        if (state == WAIT_DELAY) begin
            dly_nx = dly - DELAY_WIDTH'(1);
            if (dly == DELAY_WIDTH'(1))
                state_nx = DRIVE;
        end

        if (accept) begin
            op_nx    = TX_OP;
            movi_nx  = TX_MOVI;
            reg_a_nx = TX_REG_A;
            reg_b_nx = TX_REG_B;
            mem_nx   = TX_MEM;
            imm_nx   = TX_IMM;
            dly_nx   = TX_DELAY;
            state_nx = (TX_DELAY == '0) ? DRIVE : WAIT_DELAY;
        end
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state     <= IDLE;
            dly       <= '0;
            TRANS_CNT <= '0;
            OP        <= '0;
            MOVI      <= '0;
            REG_A     <= '0;
            REG_B     <= '0;
            MEM       <= '0;
            IMM       <= '0;
        end else begin
            state     <= state_nx;
            dly       <= dly_nx;
            TRANS_CNT <= cnt_nx;
            OP        <= op_nx;
            MOVI      <= movi_nx;
            REG_A     <= reg_a_nx;
            REG_B     <= reg_b_nx;
            MEM       <= mem_nx;
            IMM       <= imm_nx;
        end
    end

endmodule

// File: tb/tb_alu_hw_driver.sv
// Testbench for alu_hw_driver: directed scenarios plus randomized traffic
// checked every cycle against a transaction-level reference model.
module tb_alu_hw_driver;

    localparam int DW = 8;
    localparam int LW = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST;
    logic          TX_VLD;
    logic          TX_RDY;
    logic [1:0]    TX_OP, TX_MOVI;
    logic [DW-1:0] TX_REG_A, TX_REG_B, TX_MEM, TX_IMM;
    logic [LW-1:0] TX_DELAY;
    logic          ACT;
    logic [1:0]    OP, MOVI;
    logic [DW-1:0] REG_A, REG_B, MEM, IMM;
    logic          ALU_RDY;
    logic          BUSY;
    logic [CW-1:0] TRANS_CNT;

    alu_hw_driver #(
        .DATA_WIDTH (DW),
        .DELAY_WIDTH(LW),
        .CNT_WIDTH  (CW)
    ) dut (
        .CLK      (CLK),
        .RST      (RST),
        .TX_VLD   (TX_VLD),
        .TX_RDY   (TX_RDY),
        .TX_OP    (TX_OP),
        .TX_MOVI  (TX_MOVI),
        .TX_REG_A (TX_REG_A),
        .TX_REG_B (TX_REG_B),
        .TX_MEM   (TX_MEM),
        .TX_IMM   (TX_IMM),
        .TX_DELAY (TX_DELAY),
        .ACT      (ACT),
        .OP       (OP),
        .MOVI     (MOVI),
        .REG_A    (REG_A),
        .REG_B    (REG_B),
        .MEM      (MEM),
        .IMM      (IMM),
        .ALU_RDY  (ALU_RDY),
        .BUSY     (BUSY),
        .TRANS_CNT(TRANS_CNT)
    );

    always #5 CLK = ~CLK;

    int n_tests = 0;
    int n_fail  = 0;
    int cyc     = 0;
    bit armed   = 1'b0;

    always @(posedge CLK) cyc <= cyc + 1;

    task automatic cmp(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: at most one pending transaction with remaining idle cycles
    bit       m_has = 1'b0;
    int       m_rem = 0;
    int       m_cnt = 0;
    bit [1:0] m_op = '0, m_movi = '0;
    bit [7:0] m_a = '0, m_b = '0, m_mem = '0, m_imm = '0;

    always @(posedge CLK) begin : model
        bit x, a;
        if (!RST) begin
            m_has  <= 1'b0;
            m_rem  <= 0;
            m_cnt  <= 0;
            m_op   <= '0;
            m_movi <= '0;
            m_a    <= '0;
            m_b    <= '0;
            m_mem  <= '0;
            m_imm  <= '0;
        end else begin
            x = m_has && (m_rem == 0) && (ALU_RDY === 1'b1);
            a = (TX_VLD === 1'b1) && (!m_has || x);
            if (x)
                m_cnt <= (m_cnt + 1) % (1 << CW);
            if (a) begin
                m_has  <= 1'b1;
                m_rem  <= int'(TX_DELAY);
                m_op   <= TX_OP;
                m_movi <= TX_MOVI;
                m_a    <= TX_REG_A;
                m_b    <= TX_REG_B;
                m_mem  <= TX_MEM;
                m_imm  <= TX_IMM;
            end else if (x) begin
                m_has <= 1'b0;
            end else if (m_has && m_rem > 0) begin
                m_rem <= m_rem - 1;
            end
        end
    end

    int xfer_cyc[$];
    int xfer_a[$];

    always @(negedge CLK) begin
        if (armed) begin
            cmp("act", ACT, m_has && m_rem == 0);
            cmp("tx_rdy", TX_RDY,
                RST && (!m_has || (m_rem == 0 && ALU_RDY)));
            cmp("busy", BUSY, m_has);
            cmp("op", OP, m_op);
            cmp("movi", MOVI, m_movi);
            cmp("reg_a", REG_A, m_a);
            cmp("reg_b", REG_B, m_b);
            cmp("mem", MEM, m_mem);
            cmp("imm", IMM, m_imm);
            cmp("trans_cnt", TRANS_CNT, m_cnt);
            if (ACT && ALU_RDY) begin
                xfer_cyc.push_back(cyc);
                xfer_a.push_back(int'(REG_A));
            end
        end
    end

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic put(input bit v, input int a, input int d);
        TX_VLD   = v;
        TX_REG_A = a[7:0];
        TX_DELAY = d[7:0];
        TX_OP    = 2'($urandom);
        TX_MOVI  = 2'($urandom);
        TX_REG_B = 8'($urandom);
        TX_MEM   = 8'($urandom);
        TX_IMM   = 8'($urandom);
    endtask

    initial begin
        bit saw_act;
        int t0;
        RST     = 1'b0;
        ALU_RDY = 1'b1;
        put(1'b1, 0, 0);

        // Reset held with a valid transaction offered
        tick();
        armed = 1'b1;
        tick();
        tick();
        cmp("rst_act", ACT, 0);
        cmp("rst_tx_rdy", TX_RDY, 0);
        cmp("rst_busy", BUSY, 0);
        cmp("rst_cnt", TRANS_CNT, 0);

        // Four back-to-back zero-delay transfers
        RST = 1'b1;
        xfer_cyc.delete();
        xfer_a.delete();
        for (int i = 1; i <= 4; i++) begin
            put(1'b1, i, 0);
            tick();
        end
        TX_VLD = 1'b0;
        tick();
        cmp("b2b_n", xfer_a.size(), 4);
        if (xfer_a.size() == 4) begin
            for (int i = 0; i < 4; i++) begin
                cmp("b2b_reg_a", xfer_a[i], i + 1);
                cmp("b2b_consec", xfer_cyc[i], xfer_cyc[0] + i);
            end
        end
        cmp("b2b_cnt", TRANS_CNT, 4);

        // Delay of 3 idle cycles before ACT
        put(1'b1, 8'h33, 3);
        tick();
        TX_VLD = 1'b0;
        for (int i = 0; i < 3; i++) begin
            cmp("dly_idle", ACT, 0);
            tick();
        end
        cmp("dly_act", ACT, 1);
        tick();
        cmp("dly_done", ACT, 0);
        cmp("dly_cnt", TRANS_CNT, 5);

        // Backpressure: outputs frozen, no accept while stalled
        put(1'b1, 8'h11, 0);
        TX_OP   = 2'd2;
        TX_IMM  = 8'hA5;
        ALU_RDY = 1'b0;
        tick();
        put(1'b1, 8'h22, 0);
        TX_OP  = 2'd1;
        TX_IMM = 8'h5A;
        #1;
        for (int i = 0; i < 5; i++) begin
            cmp("bp_act", ACT, 1);
            cmp("bp_op", OP, 2);
            cmp("bp_imm", IMM, 8'hA5);
            cmp("bp_reg_a", REG_A, 8'h11);
            cmp("bp_tx_rdy", TX_RDY, 0);
            tick();
        end
        TX_VLD  = 1'b0;
        ALU_RDY = 1'b1;
        #1;
        cmp("bp_rel_rdy", TX_RDY, 1);
        tick();
        cmp("bp_cnt", TRANS_CNT, 6);
        cmp("bp_act_off", ACT, 0);

        // Reset while waiting out a long delay
        put(1'b1, 8'h44, 200);
        tick();
        TX_VLD = 1'b0;
        repeat (50) tick();
        cmp("lr_busy_wait", BUSY, 1);
        cmp("lr_act_wait", ACT, 0);
        RST = 1'b0;
        tick();
        RST = 1'b1;
        saw_act = 1'b0;
        for (int i = 0; i < 250; i++) begin
            saw_act |= ACT;
            tick();
        end
        cmp("lr_no_act", saw_act, 0);
        cmp("lr_busy", BUSY, 0);
        cmp("lr_cnt", TRANS_CNT, 0);

        // Counter wrap after 17 transfers with a 4-bit counter
        for (int i = 0; i < 17; i++) begin
            put(1'b1, i, 0);
            tick();
        end
        TX_VLD = 1'b0;
        tick();
        cmp("wrap_cnt", TRANS_CNT, 1);

        // Randomized traffic, checked by the model every cycle
        t0 = cyc;
        while (cyc - t0 < 4000) begin
            put($urandom_range(2, 0) != 0, int'($urandom),
                ($urandom_range(3, 0) == 0) ? int'($urandom_range(9, 0)) : 0);
            ALU_RDY = $urandom_range(3, 0) != 0;
            RST     = $urandom_range(299, 0) != 0;
            tick();
        end
        RST     = 1'b1;
        TX_VLD  = 1'b0;
        ALU_RDY = 1'b1;
        repeat (15) tick();
        cmp("end_idle", BUSY, 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
